// File: rtl/axi_rd_arbiter_pkg.sv
// rtl/axi_rd_arbiter_pkg.sv - shared types and constants for the AXI read arbiter
`timescale 1ns/1ps
package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_1B = 3'd0;
    localparam logic [2:0] SIZE_2B = 3'd1;
    localparam logic [2:0] SIZE_4B = 3'd2;

    localparam logic [3:0] DEF_INST_ID = 4'd0;
    localparam logic [3:0] DEF_DATA_ID = 4'd1;

    localparam int ID_W   = 4;
    localparam int LEN_W  = 8;
    localparam int SIZE_W = 3;
    localparam int DATA_W = 32;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// rtl/axi_rd_arbiter_if.sv - requester and AXI AR/R signal bundle for the read arbiter
`timescale 1ns/1ps
interface axi_rd_arbiter_if #(
    parameter int ADDR_W = 32
);
    import axi_rd_arbiter_pkg::*;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [LEN_W-1:0]  i_len;
    logic [SIZE_W-1:0] i_size;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              i_rlast;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [LEN_W-1:0]  d_len;
    logic [SIZE_W-1:0] d_size;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rlast;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic [SIZE_W-1:0] arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  i_req, i_addr, i_len, i_size,
        output i_gnt, i_rvalid, i_rdata, i_rlast,
        input  d_req, d_addr, d_len, d_size,
        output d_gnt, d_rvalid, d_rdata, d_rlast,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport master (
        output i_req, i_addr, i_len, i_size,
        input  i_gnt, i_rvalid, i_rdata, i_rlast,
        output d_req, d_addr, d_len, d_size,
        input  d_gnt, d_rvalid, d_rdata, d_rlast,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_rd_arb_pick.sv
// rtl/axi_rd_arb_pick.sv - two-way winner select; AXI_RD_ARB_RR_EN adds round-robin pointer input
`timescale 1ns/1ps
module axi_rd_arb_pick (
    input  logic i_inst_req,
    input  logic i_data_req,
`ifdef AXI_RD_ARB_RR_EN
    input  logic i_last_data,
`endif
    output logic o_any,
    output logic o_sel_data
);

    assign o_any = i_inst_req | i_data_req;

`ifdef AXI_RD_ARB_RR_EN
    // On a tie the side that was not served last wins.
    assign o_sel_data = i_data_req & (~i_inst_req | ~i_last_data);
`else
    assign o_sel_data = i_data_req;
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - single-outstanding AXI read arbiter for inst/data requesters; AXI_RD_ARB_RR_EN enables round-robin
`timescale 1ns/1ps
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int         ADDR_W  = 32,
    parameter logic [3:0] INST_ID = DEF_INST_ID,
    parameter logic [3:0] DATA_ID = DEF_DATA_ID
) (
    input  logic           clk,
    input  logic           rst,
    axi_rd_arbiter_if.slave bus
);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic [SIZE_W-1:0]   r_size;
    logic [ID_W-1:0]     r_id;
    logic                r_owner_data;

    logic                w_any;
    logic                w_sel_data;
    logic                w_ar_hs;
    logic                w_beat;
    logic                w_unused;

`ifdef AXI_RD_ARB_RR_EN
    logic                r_last_data;
`endif

    axi_rd_arb_pick u_pick (
        .i_inst_req (bus.i_req),
        .i_data_req (bus.d_req),
`ifdef AXI_RD_ARB_RR_EN
        .i_last_data(r_last_data),
`endif
        .o_any      (w_any),
        .o_sel_data (w_sel_data)
    );

    assign w_ar_hs = (r_state == ST_ADDR) && bus.arready;
    assign w_beat  = (r_state == ST_DATA) && bus.rvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_next = ST_ADDR;
            ST_ADDR: if (bus.arready) w_next = ST_DATA;
            ST_DATA: if (bus.rvalid && bus.rlast) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // AR fields come only from these registers so they stay stable while arready is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_id         <= '0;
            r_owner_data <= 1'b0;
        end else if (r_state == ST_IDLE && w_any) begin
            r_addr       <= w_sel_data ? bus.d_addr : bus.i_addr;
            r_len        <= w_sel_data ? bus.d_len  : bus.i_len;
            r_size       <= w_sel_data ? bus.d_size : bus.i_size;
            r_id         <= w_sel_data ? DATA_ID    : INST_ID;
            r_owner_data <= w_sel_data;
        end
    end

`ifdef AXI_RD_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_data <= 1'b0;
        end else if (w_ar_hs) begin
            r_last_data <= r_owner_data;
        end
    end
`endif

    assign bus.arvalid = (r_state == ST_ADDR);
    assign bus.araddr  = r_addr;
    assign bus.arlen   = r_len;
    assign bus.arsize  = r_size;
    assign bus.arid    = r_id;
    assign bus.arburst = BURST_INCR;
    assign bus.rready  = (r_state == ST_DATA);

    assign bus.i_gnt   = w_ar_hs & ~r_owner_data;
    assign bus.d_gnt   = w_ar_hs &  r_owner_data;

    // Beats are routed by owner alone; rid and rresp do not affect routing.
    assign bus.i_rvalid = w_beat & ~r_owner_data;
    assign bus.i_rdata  = bus.rdata;
    assign bus.i_rlast  = w_beat & ~r_owner_data & bus.rlast;
    assign bus.d_rvalid = w_beat &  r_owner_data;
    assign bus.d_rdata  = bus.rdata;
    assign bus.d_rlast  = w_beat &  r_owner_data & bus.rlast;

    assign w_unused = ^{bus.rid, bus.rresp};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - randomized self-checking bench for axi_rd_arbiter
`timescale 1ns/1ps
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    localparam logic [3:0] INST_ID = 4'h3;
    localparam logic [3:0] DATA_ID = 4'hA;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int ar_wait, ar_cycles, i_gnt_n, d_gnt_n;
        int i_beats, d_beats, i_last, d_last, i_last_beat, d_last_beat;
        int data_err, rready_err;
        bit timeout;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: pending requests and which side was served last.
    bit          last_data;
    bit          pend   [2];
    logic [31:0] m_addr [2];
    logic [7:0]  m_len  [2];
    logic [2:0]  m_size [2];

    always #5 clk = ~clk;

    axi_rd_arbiter_if #(.ADDR_W(32)) bus ();

    axi_rd_arbiter #(
        .ADDR_W (32),
        .INST_ID(INST_ID),
        .DATA_ID(DATA_ID)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic bit model_pick_data(input bit ir, input bit dr);
        if (ir && dr) begin
`ifdef AXI_RD_ARB_RR_EN
            return !last_data;
`else
            return 1'b1;
`endif
        end
        return dr;
    endfunction

    task automatic post_req(input bit is_data, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
        if (is_data) begin
            bus.d_req = 1'b1; bus.d_addr = a; bus.d_len = l; bus.d_size = s;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = a; bus.i_len = l; bus.i_size = s;
        end
        pend[is_data] = 1'b1; m_addr[is_data] = a; m_len[is_data] = l; m_size[is_data] = s;
    endtask

    task automatic do_burst(input int ar_delay, input int gap_mode, input logic [3:0] rid_v,
                            input int abort_after, output obs_t o);
        int n, b, cyc;
        bit v;
        logic [31:0] dv;
        o = '{default: '0};
        while (!bus.arvalid) begin
            if (o.ar_wait >= 20) begin o.timeout = 1'b1; return; end
            @(negedge clk);
            bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.arready = 1'b0;
            #1;
            o.ar_wait++;
        end
        o.id = bus.arid; o.addr = bus.araddr; o.len = bus.arlen;
        o.size = bus.arsize; o.burst = bus.arburst;
        for (int k = 0; k <= ar_delay; k++) begin
            if (k > 0) @(negedge clk);
            bus.arready = (k == ar_delay);
            #1;
            if (bus.arvalid && bus.araddr === o.addr && bus.arlen === o.len &&
                bus.arid === o.id && bus.arsize === o.size) o.ar_cycles++;
            o.i_gnt_n += int'(bus.i_gnt);
            o.d_gnt_n += int'(bus.d_gnt);
        end
        n = int'(o.len) + 1;
        b = 0;
        cyc = 0;
        while (b < n) begin
            @(negedge clk);
            if (cyc == 0) begin
                bus.arready = 1'b0;
                if (o.i_gnt_n > 0) bus.i_req = 1'b0;
                if (o.d_gnt_n > 0) bus.d_req = 1'b0;
            end
            if (cyc >= 200) begin o.timeout = 1'b1; return; end
            v  = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            dv = $urandom;
            bus.rvalid = v; bus.rdata = dv; bus.rid = rid_v;
            bus.rresp = 2'($urandom); bus.rlast = v && (b == n - 1);
            #1;
            if (!bus.rready) o.rready_err++;
            o.i_gnt_n += int'(bus.i_gnt);
            o.d_gnt_n += int'(bus.d_gnt);
            if (bus.i_rvalid) begin
                o.i_beats++;
                if (bus.i_rdata !== dv) o.data_err++;
                if (bus.i_rlast) begin o.i_last++; o.i_last_beat = o.i_beats; end
            end
            if (bus.d_rvalid) begin
                o.d_beats++;
                if (bus.d_rdata !== dv) o.data_err++;
                if (bus.d_rlast) begin o.d_last++; o.d_last_beat = o.d_beats; end
            end
            if (v) b++;
            cyc++;
            if (abort_after > 0 && b == abort_after) return;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.arvalid, bus.rready, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {bus.arvalid, bus.rready, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid});
        end
        n_cmp++;
        if ({bus.araddr, bus.arlen, bus.arid, bus.arsize} !== '0) begin
            n_err++;
            $display("FAIL reset_fields: got %h/%h/%h/%h want zeros", bus.araddr, bus.arlen, bus.arid, bus.arsize);
        end
        n_cmp++;
        if (bus.arburst !== BURST_INCR) begin
            n_err++; $display("FAIL reset_burst: got %b want 01", bus.arburst);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_data = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
    endtask

    task automatic test_single_inst();
        obs_t o;
        @(negedge clk);
        post_req(1'b0, 32'hBFC00000, 8'd3, SIZE_4B);
        do_burst(2, 0, INST_ID, 0, o);
        last_data = 1'b0; pend[0] = 1'b0;
        n_cmp++;
        if (o.timeout || o.id !== INST_ID || o.addr !== 32'hBFC00000 || o.len !== 8'd3 || o.size !== SIZE_4B || o.burst !== BURST_INCR) begin
            n_err++;
            $display("FAIL single_ar: got to=%0d id=%h addr=%h len=%0d size=%0d burst=%b want id=%h addr=bfc00000 len=3 size=2 burst=01",
                     o.timeout, o.id, o.addr, o.len, o.size, o.burst, INST_ID);
        end
        n_cmp++;
        if (o.ar_cycles != 3) begin n_err++; $display("FAIL single_ar_stable: got %0d cycles want 3", o.ar_cycles); end
        n_cmp++;
        if (o.i_gnt_n != 1 || o.d_gnt_n != 0) begin
            n_err++; $display("FAIL single_gnt: got i=%0d d=%0d want i=1 d=0", o.i_gnt_n, o.d_gnt_n);
        end
        n_cmp++;
        if (o.i_beats != 4 || o.d_beats != 0 || o.i_last != 1 || o.i_last_beat != 4) begin
            n_err++;
            $display("FAIL single_beats: got i=%0d d=%0d last=%0d at %0d want i=4 d=0 last=1 at 4",
                     o.i_beats, o.d_beats, o.i_last, o.i_last_beat);
        end
        n_cmp++;
        if (o.data_err != 0 || o.rready_err != 0) begin
            n_err++; $display("FAIL single_data: got data_err=%0d rready_err=%0d want 0/0", o.data_err, o.rready_err);
        end
    endtask

    task automatic test_arbitration();
        obs_t o;
        bit   win;
        @(negedge clk);
        post_req(1'b0, 32'h0000_1000, 8'd1, SIZE_4B);
        post_req(1'b1, 32'h0000_2000, 8'd0, SIZE_4B);
        for (int k = 0; k < 3; k++) begin
            win = model_pick_data(pend[0], pend[1]);
            do_burst(0, 0, win ? DATA_ID : INST_ID, 0, o);
            n_cmp++;
            if (o.timeout || o.id !== (win ? DATA_ID : INST_ID) || o.addr !== m_addr[win]) begin
                n_err++;
                $display("FAIL arb_%0d: got to=%0d id=%h addr=%h want id=%h addr=%h",
                         k, o.timeout, o.id, o.addr, win ? DATA_ID : INST_ID, m_addr[win]);
            end
            last_data = win; pend[win] = 1'b0;
            if (k == 0) begin
                n_cmp++;
                if (o.id !== DATA_ID) begin n_err++; $display("FAIL arb_first: got id=%h want %h", o.id, DATA_ID); end
                post_req(1'b1, 32'h0000_3000, 8'd0, SIZE_4B);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        @(negedge clk);
        post_req(1'b1, 32'h0000_4000, 8'd0, SIZE_2B);
        do_burst(0, 0, DATA_ID, 0, o1);
        last_data = 1'b1; pend[1] = 1'b0;
        post_req(1'b1, 32'h0000_5000, 8'd0, SIZE_2B);
        do_burst(0, 0, DATA_ID, 0, o2);
        last_data = 1'b1; pend[1] = 1'b0;
        n_cmp++;
        if (o2.timeout || o2.ar_wait != 2) begin
            n_err++; $display("FAIL b2b_bubble: got ar_wait=%0d (to=%0d) want 2", o2.ar_wait, o2.timeout);
        end
        n_cmp++;
        if (o1.d_beats != 1 || o2.d_beats != 1 || o2.addr !== 32'h0000_5000) begin
            n_err++; $display("FAIL b2b_beats: got %0d/%0d addr=%h want 1/1 addr=00005000", o1.d_beats, o2.d_beats, o2.addr);
        end
    endtask

    task automatic test_rvalid_toggle();
        obs_t o;
        @(negedge clk);
        post_req(1'b0, 32'h0000_6000, 8'd1, SIZE_4B);
        do_burst(1, 1, INST_ID, 0, o);
        last_data = 1'b0; pend[0] = 1'b0;
        n_cmp++;
        if (o.timeout || o.i_beats != 2 || o.d_beats != 0 || o.i_last != 1 || o.i_last_beat != 2 || o.data_err != 0) begin
            n_err++;
            $display("FAIL toggle: got i=%0d d=%0d last=%0d at %0d derr=%0d want i=2 d=0 last=1 at 2 derr=0",
                     o.i_beats, o.d_beats, o.i_last, o.i_last_beat, o.data_err);
        end
    endtask

    task automatic test_reset_mid_data();
        obs_t o;
        int   leak;
        @(negedge clk);
        post_req(1'b0, 32'h0000_7000, 8'd3, SIZE_4B);
        do_burst(0, 0, INST_ID, 1, o);
        pend[0] = 1'b0;
        @(negedge clk);
        bus.rvalid = 1'b1; bus.rdata = $urandom; bus.rlast = 1'b0;
        #1;
        n_cmp++;
        if (bus.i_rvalid !== 1'b1) begin n_err++; $display("FAIL rst_mid_beat2: got i_rvalid=%b want 1", bus.i_rvalid); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.arvalid, bus.rready, bus.i_rvalid, bus.d_rvalid} !== 4'b0) begin
            n_err++;
            $display("FAIL rst_mid_abort: got %b want 0000", {bus.arvalid, bus.rready, bus.i_rvalid, bus.d_rvalid});
        end
        @(negedge clk);
        rst = 1'b0;
        last_data = 1'b0;
        leak = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.rvalid = 1'b1; bus.rdata = $urandom; bus.rlast = (k == 1);
            #1;
            if ({bus.arvalid, bus.rready, bus.i_rvalid, bus.d_rvalid} !== 4'b0) leak++;
        end
        @(negedge clk);
        bus.rvalid = 1'b0; bus.rlast = 1'b0;
        n_cmp++;
        if (leak != 0) begin n_err++; $display("FAIL rst_mid_drop: got %0d active cycles want 0", leak); end
    endtask

    task automatic test_rid_mismatch();
        obs_t o;
        @(negedge clk);
        post_req(1'b1, 32'h0000_8000, 8'd2, SIZE_4B);
        do_burst(0, 2, INST_ID, 0, o);
        last_data = 1'b1; pend[1] = 1'b0;
        n_cmp++;
        if (o.timeout || o.d_beats != 3 || o.i_beats != 0 || o.d_last != 1 || o.data_err != 0) begin
            n_err++;
            $display("FAIL rid_fwd: got d=%0d i=%0d last=%0d derr=%0d want d=3 i=0 last=1 derr=0",
                     o.d_beats, o.i_beats, o.d_last, o.data_err);
        end
        post_req(1'b0, 32'h0000_9000, 8'd0, SIZE_4B);
        do_burst(0, 0, INST_ID, 0, o);
        last_data = 1'b0; pend[0] = 1'b0;
        n_cmp++;
        if (o.timeout || o.id !== INST_ID || o.i_beats != 1) begin
            n_err++; $display("FAIL rid_next: got to=%0d id=%h beats=%0d want to=0 id=%h beats=1", o.timeout, o.id, o.i_beats, INST_ID);
        end
    endtask

    task automatic test_random();
        obs_t o;
        bit   win;
        int   dly, gm, nb, ob, ol, olb, onb;
        @(negedge clk);
        for (int it = 0; it < 40; it++) begin
            for (int w = 0; w < 2; w++)
                if (!pend[w] && $urandom_range(0, 1) == 1)
                    post_req(w == 1, $urandom, 8'($urandom_range(0, 7)), 3'($urandom_range(0, 2)));
            if (!pend[0] && !pend[1])
                post_req(1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 7)), 3'($urandom_range(0, 2)));
            win = model_pick_data(pend[0], pend[1]);
            dly = $urandom_range(0, 3);
            gm  = $urandom_range(0, 2);
            do_burst(dly, gm, 4'($urandom), 0, o);
            n_cmp++;
            if (o.timeout) begin
                n_err++; $display("FAIL rand_timeout: iteration %0d got no completion want completion", it);
                break;
            end
            n_cmp++;
            if (o.id !== (win ? DATA_ID : INST_ID) || o.addr !== m_addr[win] || o.len !== m_len[win] || o.size !== m_size[win]) begin
                n_err++;
                $display("FAIL rand_ar: it=%0d got id=%h addr=%h len=%0d size=%0d want id=%h addr=%h len=%0d size=%0d",
                         it, o.id, o.addr, o.len, o.size, win ? DATA_ID : INST_ID, m_addr[win], m_len[win], m_size[win]);
            end
            n_cmp++;
            if (o.ar_cycles != dly + 1) begin
                n_err++; $display("FAIL rand_ar_stable: it=%0d got %0d want %0d", it, o.ar_cycles, dly + 1);
            end
            n_cmp++;
            if (o.i_gnt_n != (win ? 0 : 1) || o.d_gnt_n != (win ? 1 : 0)) begin
                n_err++; $display("FAIL rand_gnt: it=%0d got i=%0d d=%0d want data_owner=%0d", it, o.i_gnt_n, o.d_gnt_n, win);
            end
            nb  = int'(m_len[win]) + 1;
            ob  = win ? o.d_beats : o.i_beats;
            ol  = win ? o.d_last : o.i_last;
            olb = win ? o.d_last_beat : o.i_last_beat;
            onb = win ? o.i_beats : o.d_beats;
            n_cmp++;
            if (ob != nb || ol != 1 || olb != nb || onb != 0) begin
                n_err++;
                $display("FAIL rand_beats: it=%0d got owner=%0d last=%0d at %0d other=%0d want %0d beats last at %0d other 0",
                         it, ob, ol, olb, onb, nb, nb);
            end
            n_cmp++;
            if (o.data_err != 0 || o.rready_err != 0) begin
                n_err++; $display("FAIL rand_data: it=%0d got data_err=%0d rready_err=%0d want 0/0", it, o.data_err, o.rready_err);
            end
            last_data = win;
            pend[win] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0; bus.i_len = '0; bus.i_size = '0;
        bus.d_req = 1'b0; bus.d_addr = '0; bus.d_len = '0; bus.d_size = '0;
        bus.arready = 1'b0;
        bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0; bus.rvalid = 1'b0;
        test_reset();
        test_single_inst();
        test_arbitration();
        test_back_to_back();
        test_rvalid_toggle();
        test_reset_mid_data();
        test_rid_mismatch();
        test_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
